// File: rtl/avr_pmem_arb.sv
// avr_pmem_arb: shares one synchronous-read program-memory port between fetch, LPM and optional SPM.
// Define AVR_PMEM_SPM_EN to add the SPM word-write requester (spm_* ports, pmem_we/pmem_wdata).
module avr_pmem_arb #(
   parameter int PM_AW = 9,
   parameter int FAIR  = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [15:0]      fetch_addr,
   input  logic             fetch_flush,
   output logic             fetch_stall,
   output logic             fetch_valid,
   output logic [15:0]      fetch_data,
   input  logic             lpm_req,
   input  logic [15:0]      lpm_addr,
   output logic             lpm_ack,
   output logic [7:0]       lpm_data,
`ifdef AVR_PMEM_SPM_EN
   input  logic             spm_req,
   input  logic [15:0]      spm_addr,
   input  logic [15:0]      spm_wdata,
   output logic             spm_ack,
   output logic             pmem_we,
   output logic [15:0]      pmem_wdata,
`endif
   output logic [PM_AW-1:0] pmem_addr,
   output logic             pmem_re,
   input  logic [15:0]      pmem_rdata
);

   typedef enum logic [1:0] {
      OWN_IDLE,
      OWN_FETCH,
      OWN_LPM,
      OWN_SPM
   } owner_t;

   owner_t     r_owner;
   owner_t     w_owner_nxt;
   logic       r_flush_q;
   logic       r_bsel;
   logic       r_lpm_ack;
   logic [7:0] r_lpm_data;
   logic       w_lpm_mask;
   logic       w_lpm_grant;
   logic       w_unused;

`ifdef AVR_PMEM_SPM_EN
   logic       r_spm_ack;
   logic       w_spm_grant;

   assign w_spm_grant = spm_req & ~r_spm_ack;
   assign spm_ack     = r_spm_ack;
   assign w_unused    = ^{fetch_addr[15:PM_AW], lpm_addr[15:PM_AW+1], spm_addr[15:PM_AW]};
`else
   assign w_unused    = ^{fetch_addr[15:PM_AW], lpm_addr[15:PM_AW+1]};
`endif

   // The ack cycle is masked so a requester still holding lpm_req is not granted twice.
   assign w_lpm_mask = r_lpm_ack | ((FAIR != 0) && (r_owner == OWN_LPM));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_owner <= OWN_IDLE;
      else     r_owner <= w_owner_nxt;
   end

   always_comb begin
      w_owner_nxt = OWN_FETCH;
      w_lpm_grant = 1'b0;
      pmem_addr   = fetch_addr[PM_AW-1:0];
      pmem_re     = 1'b1;
      fetch_stall = 1'b0;
`ifdef AVR_PMEM_SPM_EN
      pmem_we     = 1'b0;
      pmem_wdata  = '0;
`endif
      if (RST) begin
         w_owner_nxt = OWN_IDLE;
         pmem_addr   = '0;
         pmem_re     = 1'b0;
      end
`ifdef AVR_PMEM_SPM_EN
      else if (w_spm_grant) begin
         w_owner_nxt = OWN_SPM;
         pmem_addr   = spm_addr[PM_AW-1:0];
         pmem_re     = 1'b0;
         pmem_we     = 1'b1;
         pmem_wdata  = spm_wdata;
         fetch_stall = 1'b1;
      end
`endif
      else if (lpm_req && !w_lpm_mask) begin
         w_owner_nxt = OWN_LPM;
         w_lpm_grant = 1'b1;
         pmem_addr   = lpm_addr[PM_AW:1];
         fetch_stall = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_flush_q  <= 1'b0;
         r_bsel     <= 1'b0;
         r_lpm_ack  <= 1'b0;
         r_lpm_data <= '0;
`ifdef AVR_PMEM_SPM_EN
         r_spm_ack  <= 1'b0;
`endif
      end else begin
         r_flush_q <= fetch_flush;
         r_lpm_ack <= (r_owner == OWN_LPM);
         if (w_lpm_grant)
            r_bsel <= lpm_addr[0];
         // Byte select comes from issue time; lpm_addr may already be changing.
         if (r_owner == OWN_LPM)
            r_lpm_data <= r_bsel ? pmem_rdata[15:8] : pmem_rdata[7:0];
`ifdef AVR_PMEM_SPM_EN
         r_spm_ack <= w_spm_grant;
`endif
      end
   end

   assign fetch_valid = (r_owner == OWN_FETCH) && !r_flush_q;
   assign fetch_data  = pmem_rdata;
   assign lpm_ack     = r_lpm_ack;
   assign lpm_data    = r_lpm_data;

endmodule

// File: tb/tb_avr_pmem_arb.sv
// tb_avr_pmem_arb: randomized scoreboard bench for avr_pmem_arb against a flash model and a
// cycle-level arbitration reference (grant history, not owner encoding).
module tb_avr_pmem_arb;
   localparam int AW   = 9;
   localparam int FAIR = 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [15:0]   fetch_addr = '0;
   logic          fetch_flush = 1'b0;
   logic          fetch_stall, fetch_valid;
   logic [15:0]   fetch_data;
   logic          lpm_req = 1'b0;
   logic [15:0]   lpm_addr = '0;
   logic          lpm_ack;
   logic [7:0]    lpm_data;
   logic [AW-1:0] pmem_addr;
   logic          pmem_re;
   logic [15:0]   pmem_rdata = '0;
`ifdef AVR_PMEM_SPM_EN
   logic          spm_req = 1'b0;
   logic [15:0]   spm_addr = '0;
   logic [15:0]   spm_wdata = '0;
   logic          spm_ack, pmem_we;
   logic [15:0]   pmem_wdata;
   logic          spm_pend = 1'b0;
   logic [15:0]   spm_a = '0, spm_d = '0;
   int            m_last_spm = -10;
   int            sq[$];
`endif

   typedef struct { int due; logic [15:0] val; } exp_t;
   typedef struct { int cyc; logic stall; logic [AW-1:0] addr; logic we; logic [15:0] wd; } iss_t;

   exp_t        fq[$];
   exp_t        lq[$];
   iss_t        iq[$];
   logic [15:0] mem     [0:(1<<AW)-1];
   logic [15:0] ref_mem [0:(1<<AW)-1];
   int          cyc = 0;
   int          n_total = 0;
   int          n_bad = 0;
   int          m_last_lpm = -10;
   logic        lpm_pend = 1'b0;
   logic        lpm_force = 1'b0;
   logic [15:0] lpm_a = '0;

   avr_pmem_arb #(.PM_AW(AW), .FAIR(FAIR)) dut (
      .CLK(CLK), .RST(RST),
      .fetch_addr(fetch_addr), .fetch_flush(fetch_flush), .fetch_stall(fetch_stall),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .lpm_req(lpm_req), .lpm_addr(lpm_addr), .lpm_ack(lpm_ack), .lpm_data(lpm_data),
`ifdef AVR_PMEM_SPM_EN
      .spm_req(spm_req), .spm_addr(spm_addr), .spm_wdata(spm_wdata), .spm_ack(spm_ack),
      .pmem_we(pmem_we), .pmem_wdata(pmem_wdata),
`endif
      .pmem_addr(pmem_addr), .pmem_re(pmem_re), .pmem_rdata(pmem_rdata)
   );

   always #5 CLK = ~CLK;

   // synchronous-read flash: data for an address appears one cycle later
   always @(posedge CLK) begin
      if (pmem_re) pmem_rdata <= mem[pmem_addr];
`ifdef AVR_PMEM_SPM_EN
      if (pmem_we) mem[pmem_addr] <= pmem_wdata;
`endif
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs, predict the grant from the arbitration rules, advance the clock.
   task automatic step(input logic [15:0] fa, input logic fl);
      logic ack_now, lpm_g, spm_g;
      logic [15:0] w;
      iss_t ie;
      exp_t e;
      fetch_addr  = fa;
      fetch_flush = fl;
      lpm_req     = lpm_pend | lpm_force;
      lpm_addr    = lpm_a;
      spm_g       = 1'b0;
`ifdef AVR_PMEM_SPM_EN
      spm_req   = spm_pend;
      spm_addr  = spm_a;
      spm_wdata = spm_d;
      spm_g     = spm_req && (cyc != m_last_spm + 1);
`endif
      ack_now = (cyc == m_last_lpm + 2);
      lpm_g   = !spm_g && lpm_req && !ack_now && !(FAIR != 0 && cyc == m_last_lpm + 1);
      ie.cyc = cyc; ie.stall = 1'b1; ie.we = 1'b0; ie.wd = '0; ie.addr = fa[AW-1:0];
      if (spm_g) begin
`ifdef AVR_PMEM_SPM_EN
         ie.addr = spm_a[AW-1:0]; ie.we = 1'b1; ie.wd = spm_d;
         ref_mem[spm_a[AW-1:0]] = spm_d;
         sq.push_back(cyc + 1);
         m_last_spm = cyc;
`endif
      end else if (lpm_g) begin
         ie.addr = lpm_a[AW:1];
         w = ref_mem[lpm_a[AW:1]];
         e.due = cyc + 2;
         e.val = {8'h00, (lpm_a[0] ? w[15:8] : w[7:0])};
         lq.push_back(e);
         m_last_lpm = cyc;
      end else begin
         ie.stall = 1'b0;
         if (!fl) begin
            e.due = cyc + 1;
            e.val = ref_mem[fa[AW-1:0]];
            fq.push_back(e);
         end
      end
      iq.push_back(ie);
      if (ack_now) lpm_pend = 1'b0;
`ifdef AVR_PMEM_SPM_EN
      if (cyc == m_last_spm + 1) spm_pend = 1'b0;
`endif
      @(posedge CLK); #1; cyc++;
   endtask

   task automatic do_reset(input int n);
      RST = 1'b1;
      fq.delete(); lq.delete(); iq.delete();
      lpm_pend = 1'b0; lpm_force = 1'b0; lpm_req = 1'b0;
      m_last_lpm = -10;
`ifdef AVR_PMEM_SPM_EN
      sq.delete(); spm_pend = 1'b0; spm_req = 1'b0; m_last_spm = -10;
`endif
      repeat (n) begin @(posedge CLK); #1; cyc++; end
      RST = 1'b0;
   endtask

   task automatic run_lpm(input logic [15:0] a);
      lpm_a = a; lpm_pend = 1'b1;
      for (int i = 0; i < 20 && lpm_pend; i++) step(16'($urandom), 1'b0);
      step(16'($urandom), 1'b0);
   endtask

   // monitor / scoreboard
   always @(negedge CLK) begin
      iss_t ie;
      exp_t e;
      logic want;
      if (RST) begin
         chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
         chk("rst_fetch_stall", 32'(fetch_stall), 32'd0);
         chk("rst_lpm_ack", 32'(lpm_ack), 32'd0);
         chk("rst_lpm_data", 32'(lpm_data), 32'd0);
         chk("rst_pmem_re", 32'(pmem_re), 32'd0);
         chk("rst_pmem_addr", 32'(pmem_addr), 32'd0);
`ifdef AVR_PMEM_SPM_EN
         chk("rst_spm_ack", 32'(spm_ack), 32'd0);
         chk("rst_pmem_we", 32'(pmem_we), 32'd0);
         chk("rst_pmem_wdata", 32'(pmem_wdata), 32'd0);
`endif
      end else begin
         if (iq.size() == 0) chk("issue_queue_depth", 32'(iq.size()), 32'd1);
         else begin
            ie = iq.pop_front();
            chk("issue_cycle", 32'(cyc), 32'(ie.cyc));
            chk("pmem_addr", 32'(pmem_addr), 32'(ie.addr));
            chk("fetch_stall", 32'(fetch_stall), 32'(ie.stall));
            chk("pmem_re", 32'(pmem_re), 32'(!ie.we));
`ifdef AVR_PMEM_SPM_EN
            chk("pmem_we", 32'(pmem_we), 32'(ie.we));
            if (ie.we) chk("pmem_wdata", 32'(pmem_wdata), 32'(ie.wd));
`endif
         end
         want = (fq.size() > 0) && (fq[0].due == cyc);
         chk("fetch_valid", 32'(fetch_valid), 32'(want));
         if (want) begin
            e = fq.pop_front();
            if (fetch_valid) chk("fetch_data", 32'(fetch_data), 32'(e.val));
         end
         want = (lq.size() > 0) && (lq[0].due == cyc);
         chk("lpm_ack", 32'(lpm_ack), 32'(want));
         if (want) begin
            e = lq.pop_front();
            chk("lpm_data", 32'(lpm_data), 32'(e.val));
         end
`ifdef AVR_PMEM_SPM_EN
         want = (sq.size() > 0) && (sq[0] == cyc);
         chk("spm_ack", 32'(spm_ack), 32'(want));
         if (want) void'(sq.pop_front());
`endif
      end
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ref_mem[i] = 16'($urandom);
         mem[i]     = ref_mem[i];
      end
      ref_mem[16] = 16'hABCD;
      mem[16]     = 16'hABCD;
      #1;
      do_reset(3);
      // sequential fetch after release
      for (int i = 0; i < 8; i++) step(16'(i), 1'b0);
      // directed LPM, both byte halves of word 0x10
      run_lpm(16'h0021);
      run_lpm(16'h0020);
      // lpm_req held high for six cycles
      lpm_a = 16'h0047; lpm_force = 1'b1;
      repeat (6) step(16'($urandom), 1'b0);
      lpm_force = 1'b0;
      repeat (4) step(16'($urandom), 1'b0);
      // single-cycle flush
      step(16'h0030, 1'b0); step(16'h0031, 1'b1); step(16'h0032, 1'b0); step(16'h0033, 1'b0);
      // random traffic, upper address bits random
      for (int i = 0; i < 400; i++) begin
         if (!lpm_pend && !lpm_req && $urandom_range(0, 4) == 0) begin
            lpm_pend = 1'b1;
            lpm_a    = 16'($urandom);
         end
         step(16'($urandom), ($urandom_range(0, 9) == 0));
      end
      for (int i = 0; i < 20 && lpm_pend; i++) step(16'($urandom), 1'b0);
      repeat (3) step(16'($urandom), 1'b0);
      // reset the cycle after an LPM issue: the ack must never appear
      lpm_pend = 1'b1; lpm_a = 16'($urandom);
      step(16'($urandom), 1'b0);
      do_reset(2);
      repeat (6) step(16'($urandom), 1'b0);
`ifdef AVR_PMEM_SPM_EN
      // SPM and LPM together: write wins, LPM follows, later fetch sees the new word
      spm_pend = 1'b1; spm_a = 16'd5; spm_d = 16'h1234;
      lpm_pend = 1'b1; lpm_a = 16'h0100;
      for (int i = 0; i < 20 && (lpm_pend || spm_pend); i++) step(16'h0007, 1'b0);
      step(16'h0005, 1'b0);
      step(16'h0005, 1'b0);
`endif
      repeat (4) step(16'($urandom), 1'b0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
